// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
// Revision: 1.0
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [2:0]            req0_ctrl,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [2:0]            req1_ctrl,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_eq,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_eq,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_eq,
    output logic                  busy,
    output logic                  grant_id
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]            r_state;
    logic                  r_last;
    logic                  r_grant;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [2:0]            r_ctrl;
    logic [DATA_WIDTH-1:0] r_res0;
    logic [DATA_WIDTH-1:0] r_res1;
    logic                  r_eq0;
    logic                  r_eq1;

    logic w_idle;
    logic w_pick;
    logic w_ready0;
    logic w_ready1;
    logic w_hs;
    logic w_rsp_take;

    // On a tie the requester not served last wins; otherwise whoever is valid.
    assign w_idle     = (r_state == c_IDLE);
    assign w_pick     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    assign w_ready0   = rst_n & w_idle & req0_valid & ~w_pick;
    assign w_ready1   = rst_n & w_idle & req1_valid & w_pick;
    assign w_hs       = w_ready0 | w_ready1;
    assign w_rsp_take = (r_state == c_RESP) && (r_grant ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_ctrl  <= 3'd0;
            r_res0  <= '0;
            r_res1  <= '0;
            r_eq0   <= 1'b0;
            r_eq1   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hs) begin
                        r_op1   <= w_pick ? req1_op1  : req0_op1;
                        r_op2   <= w_pick ? req1_op2  : req0_op2;
                        r_ctrl  <= w_pick ? req1_ctrl : req0_ctrl;
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (r_grant) begin
                        r_res1 <= alu_out;
                        r_eq1  <= alu_eq;
                    end else begin
                        r_res0 <= alu_out;
                        r_eq0  <= alu_eq;
                    end
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    if (w_rsp_take) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // ALU inputs come straight from the latch registers so they hold between ops.
    assign alu_op1     = r_op1;
    assign alu_op2     = r_op2;
    assign alu_ctrl    = r_ctrl;
    assign req0_ready  = w_ready0;
    assign req1_ready  = w_ready1;
    assign rsp0_valid  = (r_state == c_RESP) && !r_grant;
    assign rsp1_valid  = (r_state == c_RESP) && r_grant;
    assign rsp0_result = r_res0;
    assign rsp1_result = r_res1;
    assign rsp0_eq     = r_eq0;
    assign rsp1_eq     = r_eq1;
    assign busy        = !w_idle;
    assign grant_id    = r_grant;

endmodule
`default_nettype wire
